mmi_dbg_uart_host: RTL



---
 rtl/mmi_dbg_uart_host.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mmi_dbg_uart_host.sv
// UART debug host: turns 'R'/'W' command frames into single 32-bit MMIO cycles and sends the result back.
// The request registers one clock after the last frame byte; the bus may stall it for BUS_TIMEOUT clocks, and the release wait is unbounded.
module mmi_dbg_uart_host #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [4:0] OPM_RD       = 5'b01011,
    parameter logic [4:0] OPM_WR       = 5'b10011,
    parameter int         BUS_TIMEOUT  = 4095,
    parameter int         GAP_TIMEOUT  = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uartRxD,
    output logic        uartTxD,
    output logic [31:0] mmioAddr,
    output logic [4:0]  mmioOpm,
    output logic [63:0] mmioOutData,
    input  logic [63:0] mmioInData,
    input  logic [1:0]  mmioOK,
    output logic        dbgBusy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(BUS_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(BUS_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_REL, S_RSP} state_t;
    typedef enum logic [1:0] {ST_OK, ST_FAULT, ST_TMO} status_t;

    state_t          state, next_state;
    status_t         status;
    logic            rx_s1, rx_s2, rx_s3, rx_act, rx_vld;
    logic [3:0]      rx_bit;
    logic [CW-1:0]   rx_cnt;
    logic [7:0]      rx_sr;
    logic [1:0]      byte_cnt;
    logic            is_wr;
    logic [31:0]     addr_sr, data_sr, rdata;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0]      rsp_idx, load_idx;
    logic [7:0]      load_byte;
    logic            tx_act;
    logic [3:0]      tx_bit;
    logic [CW-1:0]   tx_cnt;
    logic [8:0]      tx_sr;
    logic            cmd_byte, gap_abort, req_live, bus_ack, bus_tmo;
    logic            tx_tick, tx_byte_end, last_byte;
    logic            unused_rd_hi;

    assign unused_rd_hi = ^mmioInData[63:32];
    assign dbgBusy      = (state != S_IDLE);

    // RX: bit 0 is the start bit (checked at half a bit), 1..8 data, 9 stop
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            rx_s3  <= 1'b1;
            rx_act <= 1'b0;
            rx_bit <= '0;
            rx_cnt <= '0;
            rx_sr  <= '0;
            rx_vld <= 1'b0;
        end else begin
            rx_s1  <= uartRxD;
            rx_s2  <= rx_s1;
            rx_s3  <= rx_s2;
            rx_vld <= 1'b0;
            if (!rx_act) begin
                if (rx_s3 && !rx_s2) begin
                    rx_act <= 1'b1;
                    rx_bit <= '0;
                    rx_cnt <= '0;
                end
            end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_END : BIT_END)) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_act <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_act <= 1'b0;
                    rx_vld <= rx_s2;
                end else begin
                    rx_sr <= {rx_s2, rx_sr[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    assign cmd_byte    = rx_vld && (rx_sr == 8'h52 || rx_sr == 8'h57);
    assign gap_abort   = !rx_vld && (gap_cnt == GAP_END);
    assign req_live    = (mmioOpm != 5'd0);
    assign bus_ack     = req_live && mmioOK[0];
    assign bus_tmo     = req_live && (tmo_cnt == TMO_END);
    assign tx_tick     = tx_act && (tx_cnt == BIT_END);
    assign tx_byte_end = tx_tick && (tx_bit == 4'd9);
    assign last_byte   = (rsp_idx == ((!is_wr && status == ST_OK) ? 3'd4 : 3'd0));
    assign load_idx    = tx_act ? rsp_idx + 3'd1 : rsp_idx;

    always_comb begin
        load_byte = 8'h00;
        case (load_idx)
            3'd0: begin
                if (status == ST_OK)         load_byte = is_wr ? 8'h77 : 8'h72;
                else if (status == ST_FAULT) load_byte = 8'h21;
                else                         load_byte = 8'h3F;
            end
            3'd1:    load_byte = rdata[31:24];
            3'd2:    load_byte = rdata[23:16];
            3'd3:    load_byte = rdata[15:8];
            3'd4:    load_byte = rdata[7:0];
            default: load_byte = 8'h00;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (cmd_byte) next_state = S_ADDR;
            S_ADDR: begin
                if (gap_abort) next_state = S_IDLE;
                else if (rx_vld && byte_cnt == 2'd3) next_state = is_wr ? S_DATA : S_REQ;
            end
            S_DATA: begin
                if (gap_abort) next_state = S_IDLE;
                else if (rx_vld && byte_cnt == 2'd3) next_state = S_REQ;
            end
            S_REQ:  if (bus_ack || bus_tmo) next_state = S_REL;
            S_REL:  if (mmioOK == 2'b00) next_state = S_RSP;
            S_RSP:  if (tx_byte_end && last_byte) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt    <= '0;
            is_wr       <= 1'b0;
            addr_sr     <= '0;
            data_sr     <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            status      <= ST_OK;
            rdata       <= '0;
            rsp_idx     <= '0;
            mmioAddr    <= '0;
            mmioOutData <= '0;
            mmioOpm     <= '0;
        end else begin
            // opcode is only asserted once the request state is stable, so it drops on ack/timeout
            mmioOpm <= (state == S_REQ && next_state == S_REQ) ? (is_wr ? OPM_WR : OPM_RD) : 5'd0;
            if (rx_vld || (state != S_ADDR && state != S_DATA)) gap_cnt <= '0;
            else                                                gap_cnt <= gap_cnt + GW'(1);
            case (state)
                S_IDLE: begin
                    if (cmd_byte) begin
                        is_wr    <= (rx_sr == 8'h57);
                        byte_cnt <= '0;
                        data_sr  <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                S_ADDR: begin
                    if (rx_vld) begin
                        addr_sr  <= {addr_sr[23:0], rx_sr};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_vld) begin
                        data_sr  <= {data_sr[23:0], rx_sr};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_REQ: begin
                    mmioAddr    <= addr_sr;
                    mmioOutData <= {32'h0, data_sr};
                    if (req_live) tmo_cnt <= tmo_cnt + TW'(1);
                    if (bus_ack) begin
                        status <= mmioOK[1] ? ST_FAULT : ST_OK;
                        if (!mmioOK[1]) rdata <= mmioInData[31:0];
                    end else if (bus_tmo) begin
                        status <= ST_TMO;
                    end
                end
                S_REL: rsp_idx <= '0;
                S_RSP: if (tx_byte_end) rsp_idx <= rsp_idx + 3'd1;
                default: ;
            endcase
        end
    end

    // TX: the next byte's start bit is loaded on the same clock the stop bit ends
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_act  <= 1'b0;
            tx_bit  <= '0;
            tx_cnt  <= '0;
            tx_sr   <= '1;
            uartTxD <= 1'b1;
        end else if (state != S_RSP) begin
            tx_act  <= 1'b0;
            tx_cnt  <= '0;
            uartTxD <= 1'b1;
        end else if (!tx_act || (tx_byte_end && !last_byte)) begin
            tx_act  <= 1'b1;
            tx_bit  <= '0;
            tx_cnt  <= '0;
            tx_sr   <= {1'b1, load_byte};
            uartTxD <= 1'b0;
        end else if (tx_byte_end) begin
            tx_act  <= 1'b0;
            uartTxD <= 1'b1;
        end else if (tx_tick) begin
            tx_cnt  <= '0;
            tx_bit  <= tx_bit + 4'd1;
            uartTxD <= tx_sr[0];
            tx_sr   <= {1'b1, tx_sr[8:1]};
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

endmodule
